// File: rtl/universal_register_pkg.sv
// Purpose : shared mode encoding for the universal register family.
// Latency : n/a (types and constants only).
// Flow    : n/a.
package universal_register_pkg;

  localparam int MODE_W = 3;

  // Operation select; code 7 is reserved and behaves as HOLD.
  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD       = 3'd0,
    MODE_LOAD       = 3'd1,
    MODE_TOGGLE     = 3'd2,
    MODE_SHIFT_L    = 3'd3,
    MODE_SHIFT_R    = 3'd4,
    MODE_COUNT_UP   = 3'd5,
    MODE_COUNT_DOWN = 3'd6
  } mode_e;

endpackage

// File: rtl/universal_register_next.sv
// Purpose : combinational next-state function of the universal register.
// Latency : 0 cycles (pure combinational).
// Flow    : no flow control; the caller decides whether next_q is taken.
// Ports   : mode (op select), q (current state), data (load value),
//           toggle (xor mask), serial_in (shift fill bit) -> next_q.
module universal_register_next
  import universal_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  data,
  input  logic [WIDTH-1:0]  toggle,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_LOAD:     next_q = data;
      MODE_TOGGLE:   next_q = q ^ toggle;
      MODE_SHIFT_L:  next_q = {q[WIDTH-2:0], serial_in};
      MODE_SHIFT_R:  next_q = {serial_in, q[WIDTH-1:1]};
      // Values loaded above MAX_COUNT wrap straight to zero.
      MODE_COUNT_UP: next_q = (q >= MAX_COUNT) ? '0 : q + WIDTH'(1);
      // Out-of-range values just decrement; only zero wraps.
      MODE_COUNT_DOWN: next_q = (q == '0) ? MAX_COUNT : q - WIDTH'(1);
      default:       next_q = q;  // HOLD and reserved code
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// Purpose : WIDTH-bit multi-mode register (hold/load/toggle/shift/count).
// Latency : 1 clock edge from inputs to outQ; serial_out/terminal are
//           combinational from mode and outQ.
// Flow    : no backpressure; enable=0 holds state, sync clear/preset
//           still act while disabled.
// Ports   : clock, reset (async, active-high), enable, mode, data, toggle,
//           serial_in, sync_clear, sync_preset -> outQ, serial_out, terminal.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] MAX_COUNT    = {WIDTH{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  data,
  input  logic [WIDTH-1:0]  toggle,
  input  logic              serial_in,
  input  logic              sync_clear,
  input  logic              sync_preset,
  output logic [WIDTH-1:0]  outQ,
  output logic              serial_out,
  output logic              terminal
);

  logic [WIDTH-1:0] next_q;

  universal_register_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_next (
    .mode      (mode),
    .q         (outQ),
    .data      (data),
    .toggle    (toggle),
    .serial_in (serial_in),
    .next_q    (next_q)
  );

  // Priority: clear beats preset, both beat enable, enable gates the mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            outQ <= RESET_VALUE;
    else if (sync_clear)  outQ <= '0;
    else if (sync_preset) outQ <= PRESET_VALUE;
    else if (enable)      outQ <= next_q;
  end

  // serial_out is the bit that would leave on a shift in the current mode.
  always_comb begin
    serial_out = (mode == MODE_SHIFT_L) ? outQ[WIDTH-1] : outQ[0];
  end

  // terminal depends only on mode and value, not on enable.
  always_comb begin
    terminal = 1'b0;
    if (mode == MODE_COUNT_UP)   terminal = (outQ >= MAX_COUNT);
    if (mode == MODE_COUNT_DOWN) terminal = (outQ == '0);
  end

endmodule

// File: tb/tb_universal_register.sv
module tb_universal_register;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] data;
  logic [7:0] toggle;
  logic       serial_in;
  logic       sync_clear;
  logic       sync_preset;
  logic [7:0] outQ;
  logic       serial_out;
  logic       terminal;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  universal_register #(
    .WIDTH        (8),
    .RESET_VALUE  (8'h00),
    .PRESET_VALUE (8'hFF),
    .MAX_COUNT    (8'd9)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .data        (data),
    .toggle      (toggle),
    .serial_in   (serial_in),
    .sync_clear  (sync_clear),
    .sync_preset (sync_preset),
    .outQ        (outQ),
    .serial_out  (serial_out),
    .terminal    (terminal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic en, input logic [2:0] md, input logic [7:0] d,
                       input logic [7:0] tg, input logic si, input logic clr,
                       input logic pre);
    enable = en; mode = md; data = d; toggle = tg;
    serial_in = si; sync_clear = clr; sync_preset = pre;
    #1;
  endtask

  // Push the expected post-edge value, clock once, then compare against it.
  task automatic clk_check(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check(tag, {24'd0, outQ}, {24'd0, e});
  endtask

  logic [7:0] up_seq[11];
  logic [7:0] dn_seq[3];

  initial begin
    up_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1};
    dn_seq = '{8'd1, 8'd0, 8'd9};

    reset = 1'b1;
    apply(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", {24'd0, outQ}, 32'h0);
    check("rst_term", {31'd0, terminal}, 32'd0);
    check("rst_sout", {31'd0, serial_out}, 32'd0);
    reset = 1'b0;

    // Async reset between edges
    apply(1'b1, 3'd1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("load_5a", 8'h5A);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", {24'd0, outQ}, 32'h0);
    @(posedge clock); #1;
    check("rst_hold1", {24'd0, outQ}, 32'h0);
    @(posedge clock); #1;
    check("rst_hold2", {24'd0, outQ}, 32'h0);
    reset = 1'b0;

    // Load and toggle
    apply(1'b1, 3'd1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("load_a5", 8'hA5);
    apply(1'b1, 3'd2, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0);
    clk_check("toggle_0f", 8'hAA);
    apply(1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) clk_check("toggle_0", 8'hAA);
    apply(1'b1, 3'd2, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    clk_check("toggle_ff", 8'h55);

    // Shifts
    apply(1'b1, 3'd1, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("load_81a", 8'h81);
    apply(1'b1, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("sout_shl", {31'd0, serial_out}, 32'd1);
    clk_check("shift_l", 8'h02);
    check("sout_shl_after", {31'd0, serial_out}, 32'd0);
    apply(1'b1, 3'd1, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("load_81b", 8'h81);
    apply(1'b1, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("sout_shr", {31'd0, serial_out}, 32'd1);
    clk_check("shift_r", 8'hC0);

    // Count up, clear beating an active load
    apply(1'b1, 3'd1, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
    clk_check("clr_over_load", 8'h00);
    apply(1'b1, 3'd5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      logic [7:0] prev;
      prev = (i == 0) ? 8'd0 : up_seq[i-1];
      check($sformatf("up_term%0d", i), {31'd0, terminal}, {31'd0, (prev == 8'd9)});
      clk_check($sformatf("up%0d", i), up_seq[i]);
    end
    apply(1'b1, 3'd1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("load_0c", 8'h0C);
    apply(1'b1, 3'd5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("up_term_oor", {31'd0, terminal}, 32'd1);
    clk_check("up_oor_wrap", 8'h00);

    // Count down
    apply(1'b1, 3'd1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("load_02", 8'h02);
    apply(1'b1, 3'd6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] prev;
      prev = (i == 0) ? 8'd2 : dn_seq[i-1];
      check($sformatf("dn_term%0d", i), {31'd0, terminal}, {31'd0, (prev == 8'd0)});
      clk_check($sformatf("dn%0d", i), dn_seq[i]);
    end

    // Synchronous clear/preset while disabled, reserved mode
    apply(1'b0, 3'd6, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    clk_check("clr_over_pre", 8'h00);
    apply(1'b0, 3'd6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("dn_term_disabled", {31'd0, terminal}, 32'd1);
    apply(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    clk_check("preset", 8'hFF);
    apply(1'b0, 3'd1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    clk_check("disabled_hold", 8'hFF);
    apply(1'b1, 3'd7, 8'h33, 8'hFF, 1'b0, 1'b0, 1'b0);
    clk_check("mode7_hold", 8'hFF);
    check("mode7_term", {31'd0, terminal}, 32'd0);
    check("mode7_sout", {31'd0, serial_out}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised WIDTH-bit register that generalises the single-bit D and T flip-flops into one multi-mode storage element.
- Modes: hold, parallel load (D), masked toggle (T), shift left/right, and modulo count up/down.
- Synchronous clear and preset are provided alongside the asynchronous reset.
- Used as the building block for the counters, shift registers and state holders in the rest of the design.

Parameters:
- WIDTH, 8, number of storage bits (>=2).
- RESET_VALUE, 0, value forced onto outQ by asynchronous reset.
- PRESET_VALUE, all ones (WIDTH bits), value loaded by sync_preset.
- MAX_COUNT, 2**WIDTH-1, terminal value for count modes; count range is 0..MAX_COUNT.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high; forces outQ to RESET_VALUE immediately.
- enable  input  1  1 = apply mode this edge; 0 = hold.
- mode  input  3  operation select (encoding below).
- data  input  WIDTH  parallel load value.
- toggle  input  WIDTH  per-bit toggle mask for TOGGLE mode.
- serial_in  input  1  bit shifted in during SHIFT modes.
- sync_clear  input  1  synchronous clear to 0.
- sync_preset  input  1  synchronous load of PRESET_VALUE.
- outQ  output  WIDTH  registered state.
- serial_out  output  1  bit leaving on the next shift.
- terminal  output  1  count terminal flag.

Behaviour:
- Mode encoding: 0 HOLD, 1 LOAD, 2 TOGGLE, 3 SHIFT_L, 4 SHIFT_R, 5 COUNT_UP, 6 COUNT_DOWN, 7 reserved, treated as HOLD.
- Priority, highest first: reset (async) > sync_clear > sync_preset > enable=0 > mode.
  - sync_clear and sync_preset act even when enable=0.
  - sync_clear wins over sync_preset when both are asserted.
- Reset: outQ=RESET_VALUE while reset is high, independent of clock. The first edge after deassertion evaluates normally. Reset mid-count discards the count.
- LOAD: outQ <= data. Latency is 1 edge.
- TOGGLE: outQ <= outQ ^ toggle. Mask 0 = hold; all-ones inverts every bit.
- SHIFT_L: outQ <= {outQ[WIDTH-2:0], serial_in}.
- SHIFT_R: outQ <= {serial_in, outQ[WIDTH-1:1]}.
- COUNT_UP: if outQ >= MAX_COUNT then outQ <= 0, else outQ+1. This covers out-of-range loaded values, which wrap to 0.
- COUNT_DOWN: if outQ == 0 then outQ <= MAX_COUNT, else outQ-1. Out-of-range values decrement normally.
- Arithmetic is unsigned, WIDTH bits, with no carry out.
- serial_out (combinational from outQ and mode): outQ[WIDTH-1] when mode=SHIFT_L, otherwise outQ[0].
- terminal (combinational):
  - 1 when mode=COUNT_UP and outQ >= MAX_COUNT.
  - 1 when mode=COUNT_DOWN and outQ == 0.
  - 0 otherwise, including while enable=0 in a count mode only if the value condition fails; the flag depends only on mode and outQ.
- Outputs during reset: outQ=RESET_VALUE; serial_out and terminal follow from it.

Decomposition:
- Shared package universal_register_pkg holds:
  - the 3-bit mode enumeration (MODE_HOLD ... MODE_COUNT_DOWN);
  - the MODE_W=3 constant.
- One combinational sub-module, universal_register_next, computes next state from (mode, outQ, data, toggle, serial_in).
- The top level owns the register, the priority chain and the terminal/serial_out decode.

Test Plan (WIDTH=8, RESET_VALUE=0, PRESET_VALUE=8'hFF, MAX_COUNT=9):
- Assert reset between edges with outQ=8'h5A -> outQ=0 immediately, before the next clock edge; held at 0 while reset stays high.
- LOAD data=8'hA5, then TOGGLE toggle=8'h0F -> outQ=8'hA5, then 8'hAA; toggle=0 for 3 edges -> stays 8'hAA.
- SHIFT_L from 8'h81, serial_in=0 -> 8'h02, serial_out was 1. SHIFT_R from 8'h81, serial_in=1 -> 8'hC0.
- COUNT_UP from 0 for 11 edges -> 1..9, 0, 1; terminal=1 only while outQ=9. LOAD 8'h0C then COUNT_UP -> 0.
- COUNT_DOWN from 2 -> 1, 0, 9; terminal=1 only while outQ=0.
- enable=0 with sync_clear=1 and sync_preset=1 -> outQ=0. sync_preset alone with enable=0 -> 8'hFF. mode=7, enable=1 -> holds 8'hFF.
